fp_class_seq: RTL and testbench
===============================

# fp_class_seq

Sequential, parametrised successor to the combinational IEEE-754 classifier/unpacker. Accepts one packed float per valid/ready handshake and classifies it (SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL). It returns an unbiased signed exponent and a significand with the hidden bit made explicit. Subnormals are normalised by an iterative binary-search shifter, one step per clock, instead of a combinational shifter tree. The block sits at the front of the FP datapath (adder/multiplier operand unpack) where area matters more than single-cycle subnormal latency.

## Interface
- NEXP, 5, exponent field width
- NSIG, 10, stored fraction width
- CLOG2_NSIG, $clog2(NSIG+1), shift-amount width and number of normalisation steps
- BIAS / EMIN / LAST_FLAG, from the team flags header: BIAS = 2^(NEXP-1)-1, EMIN = 1-BIAS
- Clocking: one clock; reset is synchronous and active-high
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept f this cycle
- f  in  NEXP+NSIG+1  packed float {sign, exp, frac}
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- fSign  out  1  sign bit of the accepted word
- fExp  out  NEXP+2 (signed)  unbiased exponent
- fSig  out  NSIG+1  significand, hidden bit at [NSIG]
- fFlags  out  LAST_FLAG  one-hot class, indexed by header constants
- fSa  out  CLOG2_NSIG  normalisation shift applied (0 unless subnormal)

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (IDLE) | (DONE & out_ready). out_valid = (DONE).
- Accept when in_valid & in_ready. The word is latched and flags are computed from the latched word.
- Non-subnormal accept goes to DONE and loads the results:
  - NORMAL: fExp = exp-BIAS, fSig = {1,frac}.
  - ZERO: fExp = 0, fSig = 0.
  - INFINITY/NAN: fExp = exp zero-extended (31 for half), fSig = {0,frac}.
- Subnormal accept goes to SHIFT with fSig = {0,frac}, step i = 2^(CLOG2_NSIG-1), sa = 0.
- Each SHIFT cycle performs one step:
  - If the top i bits of fSig are zero, then fSig <<= i and sa |= i.
  - Then i >>= 1.
  - After the i = 1 step: fExp = EMIN - sa, go to DONE.
- Subnormal processing is always exactly CLOG2_NSIG SHIFT cycles. There is no early exit, so latency is fixed.
- Flags: SNAN = expOnes & fracNZ & ~frac[NSIG-1]; QNAN = expOnes & frac[NSIG-1]; INFINITY = expOnes & fracZ; ZERO = expZ & fracZ; SUBNORMAL = expZ & fracNZ; NORMAL = ~expOnes & ~expZ. Exactly one flag is set in DONE.
- DONE with out_ready=0: all outputs hold, in_ready=0.
- DONE with out_ready=1 and no new input: go to IDLE.
- DONE with out_ready=1 and in_valid: the drain and the new accept happen in the same cycle. The next state follows the new word's class.
- in_valid during SHIFT is ignored (in_ready=0). Upstream must hold the word.

## Timing
- Reset: state IDLE, out_valid 0, in_ready 1, fSign 0, fExp 0, fSig 0, fFlags 0, fSa 0.
- Reset asserted in any state aborts the operation, and the reset values appear the next cycle.
- Latency, accept edge to out_valid high:
  - Non-subnormal: 1 cycle.
  - Subnormal: 1+CLOG2_NSIG cycles (5 at defaults).
- Throughput with out_ready tied high: 1 word/cycle for non-subnormals; subnormal occupies the block for 1+CLOG2_NSIG cycles.
- All outputs are registered. There is no combinational path from f to the result outputs.
- in_ready depends combinationally on out_ready (only in DONE).

## Configuration
- FP_CLASS_SEQ_DAZ_EN defined: denormals-are-zero.
  - A subnormal input is reported as ZERO: fExp = 0, fSig = 0, fSa = 0, SUBNORMAL flag never set, sign preserved.
  - 1-cycle latency; the SHIFT state and shifter are not built.
- Undefined: full subnormal normalisation as above.

## Test plan
- Reset mid-SHIFT (half, f=16'h0001 accepted, rst on 2nd SHIFT cycle) -> next cycle out_valid 0, in_ready 1, all outputs 0.
- Normal half 16'h3C00, out_ready=1 -> 1 cycle later out_valid, NORMAL, fExp 0, fSig 11'h400, fSa 0.
- Subnormal 16'h0001 -> out_valid exactly 5 cycles after accept, SUBNORMAL, fExp -24, fSig 11'h400, fSa 10. Also 16'h8200 -> fSign 1, fExp -15, fSig 11'h400, fSa 1.
- Specials:
  - 16'h7C00 -> INFINITY, fExp 31.
  - 16'h7E00 -> QNAN.
  - 16'h7C01 -> SNAN.
  - 16'h8000 -> ZERO, fSign 1.
- Backpressure: hold out_ready=0 for 4 cycles after a result -> outputs stable, in_ready 0. Then release with in_valid high on 16'h3C00 -> same-cycle drain and accept; back-to-back out_valid.
- FP_CLASS_SEQ_DAZ_EN build: 16'h0001 -> 1-cycle latency, ZERO, fExp 0, fSig 0. Parameter sweep NEXP=8/NSIG=23: f=32'h00000001 -> fExp -149, fSa 23, 6-cycle latency.

Source files
------------

// File: rtl/fp_class_seq_if.sv
// Handshake and result bundle for fp_class_seq: producer-side valid/ready/word,
// consumer-side valid/ready, and the unpacked result fields.
interface fp_class_seq_if #(
   parameter int NEXP = 5,
   parameter int NSIG = 10
);
   localparam int CLOG2_NSIG = $clog2(NSIG + 1);
   localparam int LAST_FLAG  = 6;

   logic                    in_valid;
   logic                    in_ready;
   logic [NEXP+NSIG:0]      f;
   logic                    out_valid;
   logic                    out_ready;
   logic                    fSign;
   logic signed [NEXP+1:0]  fExp;
   logic [NSIG:0]           fSig;
   logic [LAST_FLAG-1:0]    fFlags;
   logic [CLOG2_NSIG-1:0]   fSa;

   modport master (
      output in_valid, f, out_ready,
      input  in_ready, out_valid, fSign, fExp, fSig, fFlags, fSa
   );

   modport slave (
      input  in_valid, f, out_ready,
      output in_ready, out_valid, fSign, fExp, fSig, fFlags, fSa
   );
endinterface

// File: rtl/fp_class_seq.sv
// Sequential IEEE-754 classifier/unpacker with iterative subnormal normalisation.
// Define FP_CLASS_SEQ_DAZ_EN to treat subnormals as zero (no SHIFT state, no shifter).
module fp_class_seq #(
   parameter int NEXP = 5,
   parameter int NSIG = 10
) (
   input logic          clk,
   input logic          rst,
   fp_class_seq_if.slave io
);
   localparam int CLOG2_NSIG = $clog2(NSIG + 1);
   localparam int LAST_FLAG  = 6;
   localparam int BIAS       = 2 ** (NEXP - 1) - 1;
   localparam int EMIN       = 1 - BIAS;

   // One-hot flag bit positions
   localparam int F_SNAN      = 0;
   localparam int F_QNAN      = 1;
   localparam int F_INFINITY  = 2;
   localparam int F_ZERO      = 3;
   localparam int F_SUBNORMAL = 4;
   localparam int F_NORMAL    = 5;

   localparam logic signed [NEXP+1:0] BIAS_S = (NEXP + 2)'(BIAS);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

   stateT                 state;
   logic                  accept;
   logic                  sgn;
   logic [NEXP-1:0]       e;
   logic [NSIG-1:0]       frac;
   logic [LAST_FLAG-1:0]  cls;

   assign {sgn, e, frac} = io.f;
   assign io.in_ready    = (state == IDLE) || ((state == DONE) && io.out_ready);
   assign accept         = io.in_valid && io.in_ready;
   assign cls            = classify(e, frac);

   function automatic logic [LAST_FLAG-1:0] classify(input logic [NEXP-1:0] ex,
                                                     input logic [NSIG-1:0] fr);
      logic                 eOnes;
      logic                 eZero;
      logic                 fZero;
      logic [LAST_FLAG-1:0] fl;
      eOnes = &ex;
      eZero = ~|ex;
      fZero = ~|fr;
      fl    = '0;
      fl[F_SNAN]     = eOnes & ~fZero & ~fr[NSIG-1];
      fl[F_QNAN]     = eOnes & fr[NSIG-1];
      fl[F_INFINITY] = eOnes & fZero;
      fl[F_NORMAL]   = ~eOnes & ~eZero;
`ifdef FP_CLASS_SEQ_DAZ_EN
      fl[F_ZERO]      = eZero;
      fl[F_SUBNORMAL] = 1'b0;
`else
      fl[F_ZERO]      = eZero & fZero;
      fl[F_SUBNORMAL] = eZero & ~fZero;
`endif
      return fl;
   endfunction

`ifndef FP_CLASS_SEQ_DAZ_EN
   localparam logic signed [NEXP+1:0]  EMIN_S = (NEXP + 2)'(EMIN);
   localparam logic [CLOG2_NSIG-1:0]   STEP0  = {1'b1, {(CLOG2_NSIG - 1){1'b0}}};

   logic [CLOG2_NSIG-1:0] step;
   logic                  stepTake;
   logic [CLOG2_NSIG-1:0] saNext;

   // True when the top n bits of the significand are all zero.
   function automatic logic topBitsZero(input logic [NSIG:0] sig,
                                        input logic [CLOG2_NSIG-1:0] n);
      logic [NSIG:0] mask;
      mask = ~({(NSIG + 1){1'b1}} >> n);
      return (sig & mask) == '0;
   endfunction

   assign stepTake = topBitsZero(io.fSig, step);
   assign saNext   = stepTake ? (io.fSa | step) : io.fSa;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         io.out_valid <= 1'b0;
         io.fSign     <= 1'b0;
         io.fExp      <= '0;
         io.fSig      <= '0;
         io.fFlags    <= '0;
         io.fSa       <= '0;
`ifndef FP_CLASS_SEQ_DAZ_EN
         step         <= '0;
`endif
      end else if (accept) begin
         // Accept: a drain in DONE and a new word may coincide here
         io.fSign     <= sgn;
         io.fFlags    <= cls;
         io.fSa       <= '0;
         state        <= DONE;
         io.out_valid <= 1'b1;
         if (cls[F_NORMAL]) begin
            io.fExp <= $signed({2'b00, e}) - BIAS_S;
            io.fSig <= {1'b1, frac};
         end else if (&e) begin
            io.fExp <= {2'b00, e};
            io.fSig <= {1'b0, frac};
         end else begin
            io.fExp <= '0;
            io.fSig <= '0;
`ifndef FP_CLASS_SEQ_DAZ_EN
            if (cls[F_SUBNORMAL]) begin
               state        <= SHIFT;
               io.out_valid <= 1'b0;
               io.fSig      <= {1'b0, frac};
               step         <= STEP0;
            end
`endif
         end
      end
`ifndef FP_CLASS_SEQ_DAZ_EN
      else if (state == SHIFT) begin
         // One binary-search step per clock; always CLOG2_NSIG steps
         if (stepTake) io.fSig <= io.fSig << step;
         io.fSa <= saNext;
         step   <= step >> 1;
         if (step == CLOG2_NSIG'(1)) begin
            io.fExp      <= EMIN_S - $signed({{(NEXP + 2 - CLOG2_NSIG){1'b0}}, saNext});
            state        <= DONE;
            io.out_valid <= 1'b1;
         end
      end
`endif
      else if ((state == DONE) && io.out_ready) begin
         state        <= IDLE;
         io.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fp_class_seq.sv
// Directed bench for fp_class_seq: half-precision instance plus a single-precision
// instance; expectations switch with FP_CLASS_SEQ_DAZ_EN.
module tb_fp_class_seq;
   localparam logic [63:0] F_SNAN = 64'h01, F_QNAN = 64'h02, F_INF = 64'h04,
                           F_ZERO = 64'h08, F_SUB = 64'h10, F_NORM = 64'h20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nAsserts = 0;
   int   nFail = 0;
   int   lat;

   always #5 clk = ~clk;

   fp_class_seq_if #(.NEXP(5), .NSIG(10)) hIf ();
   fp_class_seq_if #(.NEXP(8), .NSIG(23)) sIf ();

   fp_class_seq #(.NEXP(5), .NSIG(10)) dutH (.clk(clk), .rst(rst), .io(hIf));
   fp_class_seq #(.NEXP(8), .NSIG(23)) dutS (.clk(clk), .rst(rst), .io(sIf));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word, accept it, and wait (out_ready low) until the result is valid.
   task automatic sendHalf(input logic [15:0] w, output int l);
      hIf.in_valid  = 1'b1;
      hIf.f         = w;
      hIf.out_ready = 1'b0;
      #1;
      chk("hInReadyAtAccept", 64'(hIf.in_ready), 64'd1);
      tick();
      l = 1;
      hIf.in_valid = 1'b0;
      while (!hIf.out_valid && l < 20) begin
         tick();
         l++;
      end
   endtask

   task automatic send32(input logic [31:0] w, output int l);
      sIf.in_valid  = 1'b1;
      sIf.f         = w;
      sIf.out_ready = 1'b0;
      tick();
      l = 1;
      sIf.in_valid = 1'b0;
      while (!sIf.out_valid && l < 20) begin
         tick();
         l++;
      end
   endtask

   task automatic drainHalf();
      hIf.out_ready = 1'b1;
      tick();
      hIf.out_ready = 1'b0;
   endtask

   task automatic checkHalf(input string tag, input int l, input int expLat,
                            input logic [63:0] fl, input logic sgn,
                            input int ex, input logic [63:0] sig, input logic [63:0] sa);
      chk({tag, ".lat"},   64'(l), 64'(expLat));
      chk({tag, ".flags"}, 64'(hIf.fFlags), fl);
      chk({tag, ".sign"},  64'(hIf.fSign), 64'(sgn));
      chk({tag, ".exp"},   $signed(hIf.fExp), 64'(ex));
      chk({tag, ".sig"},   64'(hIf.fSig), sig);
      chk({tag, ".sa"},    64'(hIf.fSa), sa);
   endtask

   initial begin
      hIf.in_valid = 1'b0; hIf.f = '0; hIf.out_ready = 1'b0;
      sIf.in_valid = 1'b0; sIf.f = '0; sIf.out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst.outValid", 64'(hIf.out_valid), 64'd0);
      chk("rst.inReady",  64'(hIf.in_ready), 64'd1);
      chk("rst.flags",    64'(hIf.fFlags), 64'd0);
      chk("rst.sig",      64'(hIf.fSig), 64'd0);
      chk("rst.sa",       64'(hIf.fSa), 64'd0);

      sendHalf(16'h3C00, lat); checkHalf("one", lat, 1, F_NORM, 1'b0, 0, 64'h400, 0); drainHalf();
      sendHalf(16'hC248, lat); checkHalf("negPi", lat, 1, F_NORM, 1'b1, 1, 64'h648, 0); drainHalf();
      sendHalf(16'h0400, lat); checkHalf("minNorm", lat, 1, F_NORM, 1'b0, -14, 64'h400, 0); drainHalf();
`ifdef FP_CLASS_SEQ_DAZ_EN
      sendHalf(16'h0001, lat); checkHalf("sub1", lat, 1, F_ZERO, 1'b0, 0, 64'h0, 0); drainHalf();
      sendHalf(16'h8200, lat); checkHalf("sub200", lat, 1, F_ZERO, 1'b1, 0, 64'h0, 0); drainHalf();
`else
      sendHalf(16'h0001, lat); checkHalf("sub1", lat, 5, F_SUB, 1'b0, -24, 64'h400, 10); drainHalf();
      sendHalf(16'h8200, lat); checkHalf("sub200", lat, 5, F_SUB, 1'b1, -15, 64'h400, 1); drainHalf();
`endif
      sendHalf(16'h7C00, lat); checkHalf("inf", lat, 1, F_INF, 1'b0, 31, 64'h000, 0); drainHalf();
      sendHalf(16'h7E00, lat); checkHalf("qnan", lat, 1, F_QNAN, 1'b0, 31, 64'h200, 0); drainHalf();
      sendHalf(16'h7C01, lat); checkHalf("snan", lat, 1, F_SNAN, 1'b0, 31, 64'h001, 0); drainHalf();
      sendHalf(16'h8000, lat); checkHalf("negZero", lat, 1, F_ZERO, 1'b1, 0, 64'h000, 0); drainHalf();

      // Backpressure, then same-cycle drain and accept
      sendHalf(16'h7C00, lat);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp.outValid", 64'(hIf.out_valid), 64'd1);
         chk("bp.inReady",  64'(hIf.in_ready), 64'd0);
         chk("bp.flags",    64'(hIf.fFlags), F_INF);
         chk("bp.exp",      $signed(hIf.fExp), 64'd31);
      end
      hIf.out_ready = 1'b1;
      hIf.in_valid  = 1'b1;
      hIf.f         = 16'h3C00;
      #1;
      chk("b2b.inReady", 64'(hIf.in_ready), 64'd1);
      tick();
      hIf.in_valid = 1'b0;
      chk("b2b.outValid", 64'(hIf.out_valid), 64'd1);
      chk("b2b.flags",    64'(hIf.fFlags), F_NORM);
      chk("b2b.exp",      $signed(hIf.fExp), 64'd0);
      chk("b2b.sig",      64'(hIf.fSig), 64'h400);
      tick();
      chk("idle.outValid", 64'(hIf.out_valid), 64'd0);
      chk("idle.inReady",  64'(hIf.in_ready), 64'd1);
      hIf.out_ready = 1'b0;

`ifndef FP_CLASS_SEQ_DAZ_EN
      // A word offered during SHIFT must not be taken
      hIf.in_valid = 1'b1;
      hIf.f        = 16'h0001;
      tick();
      hIf.f = 16'h3C00;
      #1;
      chk("shift.inReady", 64'(hIf.in_ready), 64'd0);
      for (int k = 0; k < 4; k++) tick();
      hIf.in_valid = 1'b0;
      chk("shift.outValid", 64'(hIf.out_valid), 64'd1);
      chk("shift.flags",    64'(hIf.fFlags), F_SUB);
      chk("shift.exp",      $signed(hIf.fExp), -64'sd24);
      drainHalf();
`endif

      // Reset during the second SHIFT cycle
      hIf.in_valid = 1'b1;
      hIf.f        = 16'h0001;
      tick();
      hIf.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midRst.outValid", 64'(hIf.out_valid), 64'd0);
      chk("midRst.inReady",  64'(hIf.in_ready), 64'd1);
      chk("midRst.sign",     64'(hIf.fSign), 64'd0);
      chk("midRst.exp",      $signed(hIf.fExp), 64'd0);
      chk("midRst.sig",      64'(hIf.fSig), 64'd0);
      chk("midRst.flags",    64'(hIf.fFlags), 64'd0);
      chk("midRst.sa",       64'(hIf.fSa), 64'd0);

      // Single precision instance
      send32(32'h3F800000, lat);
      chk("s.one.lat",   64'(lat), 64'd1);
      chk("s.one.flags", 64'(sIf.fFlags), F_NORM);
      chk("s.one.exp",   $signed(sIf.fExp), 64'd0);
      chk("s.one.sig",   64'(sIf.fSig), 64'h800000);
      sIf.out_ready = 1'b1; tick(); sIf.out_ready = 1'b0;
      send32(32'h00000001, lat);
`ifdef FP_CLASS_SEQ_DAZ_EN
      chk("s.sub.lat",   64'(lat), 64'd1);
      chk("s.sub.flags", 64'(sIf.fFlags), F_ZERO);
      chk("s.sub.exp",   $signed(sIf.fExp), 64'd0);
      chk("s.sub.sa",    64'(sIf.fSa), 64'd0);
`else
      chk("s.sub.lat",   64'(lat), 64'd6);
      chk("s.sub.flags", 64'(sIf.fFlags), F_SUB);
      chk("s.sub.exp",   $signed(sIf.fExp), -64'sd149);
      chk("s.sub.sig",   64'(sIf.fSig), 64'h800000);
      chk("s.sub.sa",    64'(sIf.fSa), 64'd23);
`endif
      sIf.out_ready = 1'b1; tick(); sIf.out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule
